// File: rtl/data_sync_pkg.sv
// data_sync_pkg: shared state encoding and sizing helper for the DATA_SYNC transmit scheduler
package data_sync_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    // Counter must hold both HOLD_CYCLES-1 and GAP_CYCLES-1, and never be zero-width
    function automatic int cnt_w(input int hold, input int gap);
        int w;
        w = 1;
        if ($clog2(hold) > w) w = $clog2(hold);
        if ($clog2(gap) > w) w = $clog2(gap);
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request at or above the pointer with wrap
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [IW-1:0]      ptr,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IW-1:0]      win,
    output logic               vld
);

    // Scan NUM_REQ slots starting at ptr; the first hit wins
    always_comb begin
        int j;
        gnt_oh = '0;
        win    = '0;
        vld    = 1'b0;
        j      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!vld && req[j]) begin
                vld       = 1'b1;
                win       = IW'(j);
                gnt_oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_sync_tx_sched.sv
// data_sync_tx_sched: round-robin scheduler sharing one DATA_SYNC crossing among several requesters
module data_sync_tx_sched
    import data_sync_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 3,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       bus_enable,
    output logic [WIDTH-1:0]           unsync_bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = cnt_w(HOLD_CYCLES, GAP_CYCLES);

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;
    logic               bus_enable_q, bus_enable_d;
    logic [WIDTH-1:0]   unsync_bus_q, unsync_bus_d;
    logic [NUM_REQ-1:0] arb_oh;
    logic [IW-1:0]      arb_idx;
    logic               arb_vld;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .ptr    (ptr_q),
        .req    (req),
        .gnt_oh (arb_oh),
        .win    (arb_idx),
        .vld    (arb_vld)
    );

    // Next-state: grant only from IDLE, then count out the hold and the quiet gap
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        gnt_d        = '0;
        grant_id_d   = grant_id_q;
        bus_enable_d = bus_enable_q;
        unsync_bus_d = unsync_bus_q;
        case (state_q)
            IDLE: if (arb_vld) begin
                gnt_d        = arb_oh;
                grant_id_d   = arb_idx;
                bus_enable_d = 1'b1;
                unsync_bus_d = req_data[int'(arb_idx)*WIDTH +: WIDTH];
                ptr_d        = (arb_idx == IW'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
                cnt_d        = CW'(HOLD_CYCLES-1);
                state_d      = HOLD;
            end
            HOLD: if (cnt_q == '0) begin
                bus_enable_d = 1'b0;
                cnt_d        = CW'(GAP_CYCLES-1);
                state_d      = GAP;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            GAP: if (cnt_q == '0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any transfer in flight
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            gnt_q        <= '0;
            grant_id_q   <= '0;
            bus_enable_q <= 1'b0;
            unsync_bus_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            grant_id_q   <= grant_id_d;
            bus_enable_q <= bus_enable_d;
            unsync_bus_q <= unsync_bus_d;
        end
    end

    assign gnt        = gnt_q;
    assign grant_id   = grant_id_q;
    assign bus_enable = bus_enable_q;
    assign unsync_bus = unsync_bus_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_data_sync_tx_sched.sv
// tb_data_sync_tx_sched: directed checks of grant order, hold/gap timing, async reset and withdrawal
module tb_data_sync_tx_sched;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt;
    logic [1:0]  grant_id;
    logic        busy;
    logic        bus_enable;
    logic [7:0]  unsync_bus;

    int total = 0;
    int bad   = 0;

    data_sync_tx_sched #(.WIDTH(8), .NUM_REQ(4), .HOLD_CYCLES(3), .GAP_CYCLES(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .grant_id   (grant_id),
        .busy       (busy),
        .bus_enable (bus_enable),
        .unsync_bus (unsync_bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // {gnt, grant_id, busy, bus_enable, unsync_bus} packed for compact checks
    function automatic logic [31:0] outs(input logic [3:0] g, input logic [1:0] id, input logic b,
                                         input logic be, input logic [7:0] d);
        return {16'h0, g, id, b, be, d};
    endfunction

    logic [31:0] obs;
    assign obs = outs(gnt, grant_id, busy, bus_enable, unsync_bus);

    initial begin
        // 1: reset, no requests
        step(3);
        check("rst_hold", obs, 32'h0);
        RST = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1);
            check("idle_after_rst", obs, 32'h0);
        end

        // 2: single request on requester 0
        req_data = 32'h0000_00CC;
        req = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            step(1);
            if (c == 1) req = 4'b0000;
            check("single", obs, outs((c == 1) ? 4'b0001 : 4'b0000, 2'd0, c <= 5, c <= 3, 8'hCC));
        end

        // 3: all requesting from a fresh pointer
        RST = 1'b0;
        step(1);
        RST = 1'b1;
        req_data = 32'hA3A2_A1A0;
        req = 4'b1111;
        for (int c = 1; c <= 30; c++) begin
            int g;
            int p;
            step(1);
            if (c == 25) req = 4'b0000;
            g = ((c - 1) / 6) % 4;
            p = (c - 1) % 6;
            check("all_req", obs, outs((p == 0) ? 4'(1 << g) : 4'b0000, 2'(g), p < 5, p < 3, 8'hA0 + 8'(g)));
        end

        // 4: wrap: grant 2, then 0101 gives 0 then 2
        req = 4'b0100;
        step(1);
        check("wrap_g2", obs, outs(4'b0100, 2'd2, 1'b1, 1'b1, 8'hA2));
        req = 4'b0101;
        step(6);
        check("wrap_g0", obs, outs(4'b0001, 2'd0, 1'b1, 1'b1, 8'hA0));
        step(6);
        check("wrap_g2b", obs, outs(4'b0100, 2'd2, 1'b1, 1'b1, 8'hA2));
        req = 4'b0000;
        step(5);
        check("wrap_idle", obs, outs(4'b0000, 2'd2, 1'b0, 1'b0, 8'hA2));

        // 5: async reset in the second HOLD cycle of a 0xCF transfer
        req_data = 32'hCFA2_A1A0;
        req = 4'b1000;
        step(1);
        check("mid_g3", obs, outs(4'b1000, 2'd3, 1'b1, 1'b1, 8'hCF));
        req = 4'b0000;
        step(1);
        check("mid_hold2", obs, outs(4'b0000, 2'd3, 1'b1, 1'b1, 8'hCF));
        #2 RST = 1'b0;
        #1 check("mid_async_clr", obs, 32'h0);
        step(1);
        check("mid_rst_held", obs, 32'h0);
        RST = 1'b1;
        req = 4'b1010;
        step(1);
        check("post_rst_g1", obs, outs(4'b0010, 2'd1, 1'b1, 1'b1, 8'hA1));
        req = 4'b0000;
        step(5);
        check("post_rst_idle", obs, outs(4'b0000, 2'd1, 1'b0, 1'b0, 8'hA1));

        // 6: request raised during GAP and withdrawn before IDLE
        req = 4'b0001;
        step(1);
        check("wd_g0", obs, outs(4'b0001, 2'd0, 1'b1, 1'b1, 8'hA0));
        req = 4'b0000;
        step(3);
        check("wd_gap1", obs, outs(4'b0000, 2'd0, 1'b1, 1'b0, 8'hA0));
        req = 4'b0100;
        step(1);
        check("wd_gap2", obs, outs(4'b0000, 2'd0, 1'b1, 1'b0, 8'hA0));
        req = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            step(1);
            check("wd_quiet", obs, outs(4'b0000, 2'd0, 1'b0, 1'b0, 8'hA0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_sync_tx_sched.md
# data_sync_tx_sched

Source-domain scheduler that shares one `DATA_SYNC` crossing between several requesters. Round-robin arbitration picks one requester and registers its word onto `unsync_bus`. It holds `bus_enable` high long enough for the destination synchronizer to sample it, then enforces a quiet gap before the next transfer. It sits directly in front of the `DATA_SYNC` instance, in the sending clock domain.

## Interface
- `WIDTH`, 8: bus width; matches the `DATA_SYNC` `WIDTH`.
- `NUM_REQ`, 4: number of requesters; at least 2.
- `HOLD_CYCLES`, 3: cycles `bus_enable` stays high; at least 1; set at integration to cover destination `STAGES` plus the clock ratio.
- `GAP_CYCLES`, 2: cycles `bus_enable` stays low after a hold; at least 1.
- `CLK` input, 1: single clock, rising edge.
- `RST` input, 1: asynchronous, active-low reset.
- `req` input, `NUM_REQ`: level request per requester.
- `req_data` input, `NUM_REQ*WIDTH`: word i is in bits `[i*WIDTH +: WIDTH]`.
- `gnt` output, `NUM_REQ`: one-hot, one-cycle accept pulse.
- `grant_id` output, `$clog2(NUM_REQ)`: index of the current or last winner.
- `busy` output, 1: high whenever state is not IDLE.
- `bus_enable` output, 1: drives `DATA_SYNC.bus_enable`.
- `unsync_bus` output, `WIDTH`: drives `DATA_SYNC.unsync_bus`.

## Operation
- States: IDLE, HOLD, GAP.
- Reset (asynchronous, `RST`=0) forces all outputs to their reset values, which are also their values after reset release:
  - `gnt`=0, `grant_id`=0, `busy`=0, `bus_enable`=0, `unsync_bus`=0.
  - State=IDLE, round-robin pointer=0, counter=0.
- IDLE, `req`==0: no change.
- IDLE, `req`!=0, on the clock edge:
  - Winner = first set bit scanning from the pointer upward, with wrap-around.
  - `unsync_bus` <= winner's `req_data`; `bus_enable` <= 1; `gnt[winner]` <= 1; `grant_id` <= winner.
  - Pointer <= (winner+1) mod `NUM_REQ`; counter <= `HOLD_CYCLES-1`; state <= HOLD.
- HOLD:
  - `gnt` <= 0; `bus_enable` stays 1; `unsync_bus` stable.
  - Counter==0: `bus_enable` <= 0, counter <= `GAP_CYCLES-1`, state <= GAP.
  - Otherwise the counter decrements.
- GAP:
  - `bus_enable`=0; `unsync_bus` keeps the last word and is never changed outside a grant.
  - Counter==0: state <= IDLE. Otherwise the counter decrements.
- Requester rules:
  - Hold `req` and keep `req_data` stable until `gnt`.
  - Withdrawing `req` before `gnt` is legal and produces no transfer.
  - `req` is only sampled in IDLE, so no double grant is possible even if `req` stays high after `gnt`.
- Changes to `req_data` outside the sampling edge have no effect.

## Timing
- Grant latency: `req` visible in IDLE before edge k. Then `gnt`, `bus_enable` and `unsync_bus` all update at edge k and are aligned in the same cycle.
- `gnt` width: exactly 1 cycle.
- `bus_enable` high time: exactly `HOLD_CYCLES` cycles, and `unsync_bus` does not change during it.
- Low time between transfers: at least `GAP_CYCLES`+1 cycles (GAP plus the IDLE sampling cycle).
- Minimum spacing between `bus_enable` rising edges: `HOLD_CYCLES`+`GAP_CYCLES`+1 cycles, which is 6 at the defaults.
- `busy` is combinational from the state register: 1 during HOLD and GAP.
- Reset asserted mid-HOLD or mid-GAP clears the outputs immediately, without waiting for a clock edge. The transfer in flight is dropped and is not replayed.
- Reset release: first possible grant is at the first clock edge with `RST`=1.

## Structure
- Package `data_sync_pkg`:
  - State enum (IDLE, HOLD, GAP).
  - Counter width function, `max($clog2(HOLD_CYCLES), $clog2(GAP_CYCLES), 1)`.
- Sub-module `rr_arbiter`:
  - Combinational: pointer and `req` in, one-hot winner and index out.
  - Pointer register stays in the parent.
- Parent holds the FSM, counter, and output registers.

## Test plan
All scenarios use `WIDTH`=8, `NUM_REQ`=4, `HOLD_CYCLES`=3, `GAP_CYCLES`=2.
1. **Reset, no requests:** hold `RST`=0, then release with `req`=0. All outputs stay 0 for 20 cycles.
2. **Single request:** `req`=0001, word0=0xCC.
   - `gnt`=0001 for 1 cycle.
   - `bus_enable`=1 for 3 cycles with `unsync_bus`=0xCC; `busy` for 5 cycles.
   - Then `bus_enable` low, `unsync_bus` still 0xCC.
3. **All requesting:** `req`=1111 held, words 0xA0–0xA3.
   - Grant order 0,1,2,3,0.
   - `bus_enable` rises every 6 cycles; `unsync_bus` follows 0xA0, 0xA1, 0xA2, 0xA3, 0xA0.
4. **Round-robin wrap:** after a grant to 2, `req`=0101. Next grant is 0, then 2.
5. **Reset mid-HOLD:** drop `RST` in the 2nd HOLD cycle of a 0xCF transfer.
   - `bus_enable`, `unsync_bus` and `busy` go to 0 before the next edge.
   - After release, `req`=1010 grants 1 first (pointer=0).
6. **Withdrawal during GAP:** `req`=0100 asserted during GAP, dropped before IDLE. No `gnt` and no `bus_enable`.
